dcache: RTL and testbench
=========================

DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameter INDEX_BITS, default 6, number of line-index bits (64 lines).
REQ-002 Parameter LINE_WORDS_LOG2, default 2, words per line as log2 (4 words, 16 bytes).
REQ-003 Signal clock, input, 1, rising-edge clock.
REQ-004 Signal reset_n, input, 1, asynchronous active-low reset.
REQ-005 Signal cache_rd, input, 1, CPU read request, held until accepted.
REQ-006 Signal cache_wr, input, 1, CPU write request, held until accepted.
REQ-007 Signal cache_addr, input, 32, CPU byte address; bits [1:0] are ignored.
REQ-008 Signal cache_wr_data, input, 32, CPU write data.
REQ-009 Signal cache_wr_be, input, 4, CPU write byte enables; bit i enables byte [8i+7:8i].
REQ-010 Signal cache_data, output, 32, read data; valid in the cycle a read is accepted.
REQ-011 Signal cache_waitrequest, output, 1, high while a pending CPU request is not accepted.
REQ-012 Signal mem_rd, output, 1, backing-memory word read request.
REQ-013 Signal mem_wr, output, 1, backing-memory word write request.
REQ-014 Signal mem_addr, output, 32, backing-memory byte address, word aligned.
REQ-015 Signal mem_wr_data, output, 32, backing-memory write data.
REQ-016 Signal mem_wr_be, output, 4, backing-memory write byte enables.
REQ-017 Signal mem_waitrequest, input, 1, backing memory stalls the current request.
REQ-018 Signal mem_rd_data, input, 32, backing-memory read data.
REQ-019 Signal mem_rd_valid, input, 1, mem_rd_data valid; responses return in request order.

Function
REQ-020 The cache SHALL be direct-mapped, write-through and no-write-allocate; tag = addr[31:2+LINE_WORDS_LOG2+INDEX_BITS].
REQ-021 A CPU request SHALL be accepted in a cycle where (cache_rd|cache_wr)=1 and cache_waitrequest=0; cache_waitrequest SHALL be 0 whenever no request is present.
REQ-022 A read hit SHALL be accepted in the same cycle (zero wait states), with cache_data taken from async-read data array.
REQ-023 The FSM SHALL have states IDLE, REFILL_REQ, REFILL_WAIT, WRITE.
REQ-024 IDLE, read miss: cache_waitrequest=1, latch line base address, go to REFILL_REQ.
REQ-025 REFILL_REQ SHALL assert mem_rd with mem_addr = base + 4*k, k=0..2^LINE_WORDS_LOG2-1, advancing k only when mem_waitrequest=0; after the last word is accepted go to REFILL_WAIT.
REQ-026 Each mem_rd_valid in REFILL_REQ or REFILL_WAIT SHALL write mem_rd_data to the next word of the line; beat counter counts independently of request counter.
REQ-027 After the last beat: write tag, set valid, return to IDLE; the held read then hits (accepted the cycle after the last beat).
REQ-028 IDLE, write (hit or miss): cache_waitrequest=1, go to WRITE; WRITE SHALL drive mem_wr with cache address/data/be unchanged.
REQ-029 In WRITE, the cycle mem_waitrequest=0: CPU write accepted (cache_waitrequest=0), if tag hit then merge enabled bytes into the cached word, return to IDLE.
REQ-030 cache_rd and cache_wr both high SHALL be treated as a write.
REQ-031 mem_rd_valid received in IDLE or WRITE SHALL be ignored.
REQ-032 mem_rd and mem_wr SHALL never be asserted in the same cycle.

Reset
REQ-033 During reset: all valid bits 0, FSM IDLE, counters 0, mem_rd=0, mem_wr=0, cache_waitrequest=0 when no request present; data and tag arrays are not reset.
REQ-034 Reset asserted mid-refill SHALL discard the partial line (valid stays 0).

Structure
REQ-035 The dcache_state_t enum and the LINE_WORDS_LOG2 default SHALL live in package pipTypes.
REQ-036 One sub-module dcache_array SHALL hold the tag/valid/data storage (async read, sync byte-enabled write); control stays in dcache.

Verification
REQ-037 Cold read 0x100, memory returns 0xA0..0xA3 for 0x100..0x10C, 1-cycle mem latency -> four mem_rd at 0x100,0x104,0x108,0x10C; read accepted with cache_data=0xA0 the cycle after the 4th beat.
REQ-038 Then read 0x108 -> accepted in same cycle with cache_data=0xA2, no mem_rd.
REQ-039 Write 0x104 data 0xDEADBEEF be=4'b0011 with mem_waitrequest high 3 cycles -> cache_waitrequest high 4 cycles, one mem_wr; subsequent read 0x104 returns 0xA1 upper half merged with 0xBEEF lower half, no mem_rd.
REQ-040 Write miss to 0x2000 then read 0x2000 -> write causes no mem_rd; read triggers a full refill.
REQ-041 0x100 and 0x500 (same index, INDEX_BITS=6) alternating reads -> every access refills (conflict eviction).
REQ-042 reset_n pulsed after 2 refill beats, then read 0x100 -> stray beats ignored, full 4-word refill reissued, correct data returned.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the data cache.
package pipTypes;

  localparam int unsigned INDEX_BITS_DEF      = 6;
  localparam int unsigned LINE_WORDS_LOG2_DEF = 2;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REFILL_REQ  = 2'd1,
    REFILL_WAIT = 2'd2,
    WRITE       = 2'd3
  } dcache_state_t;

endpackage

// File: rtl/dcache_if.sv
// CPU-side and backing-memory-side buses of the data cache.
interface dcache_if;

  logic        cache_rd;
  logic        cache_wr;
  logic [31:0] cache_addr;
  logic [31:0] cache_wr_data;
  logic [3:0]  cache_wr_be;
  logic [31:0] cache_data;
  logic        cache_waitrequest;

  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_be;
  logic        mem_waitrequest;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;

  // The cache itself.
  modport slave (
    input  cache_rd, cache_wr, cache_addr, cache_wr_data, cache_wr_be,
    output cache_data, cache_waitrequest,
    output mem_rd, mem_wr, mem_addr, mem_wr_data, mem_wr_be,
    input  mem_waitrequest, mem_rd_data, mem_rd_valid
  );

  // CPU plus backing memory.
  modport master (
    output cache_rd, cache_wr, cache_addr, cache_wr_data, cache_wr_be,
    input  cache_data, cache_waitrequest,
    input  mem_rd, mem_wr, mem_addr, mem_wr_data, mem_wr_be,
    output mem_waitrequest, mem_rd_data, mem_rd_valid
  );

endinterface

// File: rtl/dcache_array.sv
// Tag/valid/data storage: asynchronous read, synchronous byte-enabled write.
module dcache_array
  import pipTypes::*;
#(
  parameter  int unsigned INDEX_BITS      = INDEX_BITS_DEF,
  parameter  int unsigned LINE_WORDS_LOG2 = LINE_WORDS_LOG2_DEF,
  localparam int unsigned TAG_BITS        = 30 - LINE_WORDS_LOG2 - INDEX_BITS
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [INDEX_BITS-1:0]      rd_index_i,
  input  logic [LINE_WORDS_LOG2-1:0] rd_word_i,
  output logic [TAG_BITS-1:0]        rd_tag_o,
  output logic                       rd_valid_o,
  output logic [31:0]                rd_data_o,
  input  logic                       wr_en_i,
  input  logic [INDEX_BITS-1:0]      wr_index_i,
  input  logic [LINE_WORDS_LOG2-1:0] wr_word_i,
  input  logic [31:0]                wr_data_i,
  input  logic [3:0]                 wr_be_i,
  input  logic                       tag_wr_i,
  input  logic [TAG_BITS-1:0]        tag_i,
  input  logic                       inval_i
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned WORDS = 1 << LINE_WORDS_LOG2;

  logic [31:0]         data_q [LINES][WORDS];
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [LINES-1:0]    valid_q;

  assign rd_data_o  = data_q[rd_index_i][rd_word_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wr_be_i[b]) data_q[wr_index_i][wr_word_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
    if (tag_wr_i) tag_q[wr_index_i] <= tag_i;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      valid_q             <= '0;
    else if (tag_wr_i) valid_q[wr_index_i] <= 1'b1;
    else if (inval_i)  valid_q[wr_index_i] <= 1'b0;
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
module dcache
  import pipTypes::*;
#(
  parameter int unsigned INDEX_BITS      = INDEX_BITS_DEF,
  parameter int unsigned LINE_WORDS_LOG2 = LINE_WORDS_LOG2_DEF
) (
  input logic     clock,
  input logic     reset_n,
  dcache_if.slave bus
);

  localparam int unsigned TAG_BITS = 30 - LINE_WORDS_LOG2 - INDEX_BITS;

  dcache_state_t                      state_q, state_d;
  logic [TAG_BITS+INDEX_BITS-1:0]     base_q, base_d;
  logic [LINE_WORDS_LOG2-1:0]         req_cnt_q, req_cnt_d;
  logic [LINE_WORDS_LOG2-1:0]         beat_cnt_q, beat_cnt_d;

  logic [TAG_BITS-1:0]        cpu_tag, rd_tag;
  logic [INDEX_BITS-1:0]      cpu_index, arr_wr_index;
  logic [LINE_WORDS_LOG2-1:0] cpu_word, arr_wr_word;
  logic [31:0]                rd_data, arr_wr_data;
  logic [3:0]                 arr_wr_be;
  logic                       rd_valid, hit, cpu_req;
  logic                       arr_wr_en, tag_wr, inval;
  logic                       addr_unused;

  assign cpu_word    = bus.cache_addr[2 +: LINE_WORDS_LOG2];
  assign cpu_index   = bus.cache_addr[2+LINE_WORDS_LOG2 +: INDEX_BITS];
  assign cpu_tag     = bus.cache_addr[31 -: TAG_BITS];
  assign hit         = rd_valid && (rd_tag == cpu_tag);
  assign cpu_req     = bus.cache_rd | bus.cache_wr;
  assign addr_unused = ^bus.cache_addr[1:0];

  dcache_array #(
    .INDEX_BITS      (INDEX_BITS),
    .LINE_WORDS_LOG2 (LINE_WORDS_LOG2)
  ) u_array (
    .clock      (clock),
    .reset_n    (reset_n),
    .rd_index_i (cpu_index),
    .rd_word_i  (cpu_word),
    .rd_tag_o   (rd_tag),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data),
    .wr_en_i    (arr_wr_en),
    .wr_index_i (arr_wr_index),
    .wr_word_i  (arr_wr_word),
    .wr_data_i  (arr_wr_data),
    .wr_be_i    (arr_wr_be),
    .tag_wr_i   (tag_wr),
    .tag_i      (base_q[INDEX_BITS +: TAG_BITS]),
    .inval_i    (inval)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      req_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      req_cnt_q  <= req_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    base_d                = base_q;
    req_cnt_d             = req_cnt_q;
    beat_cnt_d            = beat_cnt_q;
    bus.cache_waitrequest = 1'b0;
    bus.cache_data        = rd_data;
    bus.mem_rd            = 1'b0;
    bus.mem_wr            = 1'b0;
    bus.mem_addr          = '0;
    bus.mem_wr_data       = '0;
    bus.mem_wr_be         = '0;
    arr_wr_en             = 1'b0;
    arr_wr_index          = base_q[INDEX_BITS-1:0];
    arr_wr_word           = beat_cnt_q;
    arr_wr_data           = bus.mem_rd_data;
    arr_wr_be             = '1;
    tag_wr                = 1'b0;
    inval                 = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cache_wr) begin
          bus.cache_waitrequest = 1'b1;
          state_d               = WRITE;
        end else if (bus.cache_rd && !hit) begin
          // Invalidate up front so an interrupted refill never leaves a stale line visible.
          bus.cache_waitrequest = 1'b1;
          base_d                = bus.cache_addr[31:2+LINE_WORDS_LOG2];
          req_cnt_d             = '0;
          beat_cnt_d            = '0;
          inval                 = 1'b1;
          arr_wr_index          = cpu_index;
          state_d               = REFILL_REQ;
        end
      end
      REFILL_REQ, REFILL_WAIT: begin
        bus.cache_waitrequest = cpu_req;
        if (state_q == REFILL_REQ) begin
          bus.mem_rd   = 1'b1;
          bus.mem_addr = {base_q, req_cnt_q, 2'b00};
          if (!bus.mem_waitrequest) begin
            req_cnt_d = req_cnt_q + 1'b1;
            if (req_cnt_q == '1) state_d = REFILL_WAIT;
          end
        end
        if (bus.mem_rd_valid) begin
          arr_wr_en  = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == '1) begin
            tag_wr  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WRITE: begin
        bus.mem_wr            = 1'b1;
        bus.mem_addr          = {bus.cache_addr[31:2], 2'b00};
        bus.mem_wr_data       = bus.cache_wr_data;
        bus.mem_wr_be         = bus.cache_wr_be;
        bus.cache_waitrequest = cpu_req && bus.mem_waitrequest;
        if (!bus.mem_waitrequest) begin
          if (hit) begin
            arr_wr_en    = 1'b1;
            arr_wr_index = cpu_index;
            arr_wr_word  = cpu_word;
            arr_wr_data  = bus.cache_wr_data;
            arr_wr_be    = bus.cache_wr_be;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache with a latency/stall-configurable memory model.
module tb_dcache;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dcache_if bus();

  dcache #(.INDEX_BITS(6), .LINE_WORDS_LOG2(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Backing memory: untouched words come from mem_init, written words from mem.
  logic [31:0] mem [int unsigned];
  int unsigned lat_cfg    = 1;
  int unsigned stall_cfg  = 0;
  int unsigned stall_used = 0;
  logic [3:0]  vpipe      = '0;
  logic [31:0] dpipe [4];

  int          rd_cnt   = 0;
  int          wr_cnt   = 0;
  int          beat_cnt = 0;
  logic [31:0] rd_log [$];
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [3:0]  last_wr_be   = '0;
  logic        both_seen    = 1'b0;

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110) return 32'hA0 + ((a - 32'h100) >> 2);
    return {a[15:0], 16'h1234};
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return mem_init(a);
  endfunction

  assign bus.mem_waitrequest = bus.mem_wr && (stall_used < stall_cfg);
  assign bus.mem_rd_valid    = vpipe[lat_cfg-1];
  assign bus.mem_rd_data     = dpipe[lat_cfg-1];

  always @(posedge clock) begin
    logic [31:0] old, merged;
    vpipe    <= {vpipe[2:0], bus.mem_rd && !bus.mem_waitrequest};
    dpipe[0] <= mem_read(bus.mem_addr);
    for (int i = 1; i < 4; i++) dpipe[i] <= dpipe[i-1];
    if (bus.mem_rd && !bus.mem_waitrequest) begin
      rd_cnt <= rd_cnt + 1;
      rd_log.push_back(bus.mem_addr);
    end
    if (bus.mem_wr && !bus.mem_waitrequest) begin
      old = mem_read(bus.mem_addr);
      for (int b = 0; b < 4; b++)
        merged[8*b +: 8] = bus.mem_wr_be[b] ? bus.mem_wr_data[8*b +: 8] : old[8*b +: 8];
      mem[bus.mem_addr] = merged;
      stall_used   <= 0;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.mem_addr;
      last_wr_data <= bus.mem_wr_data;
      last_wr_be   <= bus.mem_wr_be;
    end else if (bus.mem_wr) begin
      stall_used <= stall_used + 1;
    end
    if (bus.mem_rd_valid) beat_cnt <= beat_cnt + 1;
    if (bus.mem_rd && bus.mem_wr) both_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            output logic [31:0] d, output int waits);
    @(posedge clock); #1;
    bus.cache_rd      = rd;
    bus.cache_wr      = wr;
    bus.cache_addr    = a;
    bus.cache_wr_data = wd;
    bus.cache_wr_be   = be;
    waits = 0;
    d     = 'x;
    repeat (100) begin
      @(negedge clock);
      if (!bus.cache_waitrequest) begin
        d = bus.cache_data;
        break;
      end
      waits++;
    end
    @(posedge clock); #1;
    bus.cache_rd = 1'b0;
    bus.cache_wr = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                         input int exp_waits, input int exp_nrd);
    logic [31:0] d;
    int          waits, r0;
    r0 = rd_cnt;
    cpu_access(1'b1, 1'b0, a, '0, '0, d, waits);
    chk({tag, "_data"},  d, exp_d);
    chk({tag, "_waits"}, waits, exp_waits);
    chk({tag, "_nrd"},   rd_cnt - r0, exp_nrd);
    if (exp_nrd == 4 && rd_cnt - r0 == 4) begin
      for (int k = 0; k < 4; k++)
        chk({tag, "_rdaddr"}, rd_log[r0+k], {a[31:4], 4'h0} + 32'(4*k));
    end
  endtask

  task automatic do_write(input string tag, input logic both, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input int exp_waits);
    logic [31:0] d;
    int          waits, r0, w0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    cpu_access(both, 1'b1, a, wd, be, d, waits);
    chk({tag, "_waits"},  waits, exp_waits);
    chk({tag, "_nrd"},    rd_cnt - r0, 0);
    chk({tag, "_nwr"},    wr_cnt - w0, 1);
    chk({tag, "_wraddr"}, last_wr_addr, a);
    chk({tag, "_wrdata"}, last_wr_data, wd);
    chk({tag, "_wrbe"},   {28'h0, last_wr_be}, {28'h0, be});
  endtask

  initial begin
    int b0;
    bus.cache_rd      = 1'b0;
    bus.cache_wr      = 1'b0;
    bus.cache_addr    = '0;
    bus.cache_wr_data = '0;
    bus.cache_wr_be   = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_waitreq", bus.cache_waitrequest, 1'b0);
    chk("rst_mem_rd",  bus.mem_rd, 1'b0);
    chk("rst_mem_wr",  bus.mem_wr, 1'b0);
    reset_n = 1'b1;

    do_read("cold_100", 32'h100, 32'h0000_00A0, 6, 4);
    do_read("hit_108",  32'h108, 32'h0000_00A2, 0, 0);

    stall_cfg = 3;
    do_write("wr_104", 1'b0, 32'h104, 32'hDEAD_BEEF, 4'b0011, 4);
    stall_cfg = 0;
    do_read("merge_104", 32'h104, 32'h0000_BEEF, 0, 0);

    do_write("wrmiss_2000", 1'b0, 32'h2000, 32'h1122_3344, 4'b1111, 1);
    do_read("rd_2000", 32'h2000, 32'h1122_3344, 6, 4);

    do_read("conf_500a", 32'h500, 32'h0500_1234, 6, 4);
    do_read("conf_100",  32'h100, 32'h0000_00A0, 6, 4);
    do_read("conf_500b", 32'h500, 32'h0500_1234, 6, 4);

    // Reset in the middle of a slow refill; the remaining beats land after reset.
    repeat (5) @(posedge clock);
    lat_cfg = 3;
    b0 = beat_cnt;
    @(posedge clock); #1;
    bus.cache_rd   = 1'b1;
    bus.cache_addr = 32'h100;
    repeat (100) begin
      @(negedge clock);
      if (beat_cnt - b0 >= 2) break;
    end
    chk("mid_two_beats", beat_cnt - b0, 2);
    reset_n      = 1'b0;
    bus.cache_rd = 1'b0;
    #1;
    chk("mid_rst_mem_rd",  bus.mem_rd, 1'b0);
    chk("mid_rst_waitreq", bus.cache_waitrequest, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(posedge clock);
    chk("mid_stray_beats", beat_cnt - b0, 4);
    #1;
    chk("mid_idle_waitreq", bus.cache_waitrequest, 1'b0);
    lat_cfg = 1;
    do_read("rerd_100", 32'h100, 32'h0000_00A0, 6, 4);
    do_read("rerd_10c", 32'h10C, 32'h0000_00A3, 0, 0);
    do_read("rerd_104", 32'h104, 32'h0000_BEEF, 0, 0);

    do_write("both_108", 1'b1, 32'h108, 32'h5566_7788, 4'b1100, 1);
    do_read("both_rd_108", 32'h108, 32'h5566_00A2, 0, 0);

    chk("rd_wr_exclusive", both_seen, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
